// File: rtl/key_debouncer.sv
// key_debouncer: synchronizes, debounces and edge-detects the piano key inputs.
// Each key keeps its own tick counter. The tick is shared and comes from one prescaler.
// A key's debounced level changes only after its synchronized input has differed
// from that level for DEB_TICKS consecutive ticks without bouncing back.
module key_debouncer #(
    parameter int unsigned N_KEYS     = 12,
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned DEB_TICKS  = 8,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N_KEYS-1:0] keys_raw_i,
    output logic [N_KEYS-1:0] keys_o,
    output logic [N_KEYS-1:0] press_o,
    output logic [N_KEYS-1:0] release_o,
    output logic              any_key_o,
    output logic [3:0]        last_key_o,
    output logic              last_valid_o
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(DEB_TICKS + 1);
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_TICKS - 1);

    logic [N_KEYS-1:0] raw_pol;
    logic [N_KEYS-1:0] sync1_q, sync2_q;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic              tick;
    logic [CNT_W-1:0]  cnt_q [N_KEYS];
    logic [CNT_W-1:0]  cnt_d [N_KEYS];
    logic [N_KEYS-1:0] keys_q, keys_d;
    logic [N_KEYS-1:0] press_q, press_d;
    logic [N_KEYS-1:0] release_q, release_d;
    logic              any_key_q, any_key_d;
    logic [3:0]        last_key_q, last_key_d;
    logic              last_valid_q, last_valid_d;
    logic              found;

    // Polarity fix-up happens before the synchronizer so all later logic sees 1 = pressed.
    assign raw_pol = ACTIVE_LOW ? ~keys_raw_i : keys_raw_i;

    // Shared debounce time base: tick fires once per TICK_DIV cycles.
    assign tick  = (pre_q == PRE_MAX);
    assign pre_d = tick ? '0 : pre_q + PRE_W'(1);

    // Per-key debounce counters, debounced levels, edge strobes and last-pressed tracking.
    always_comb begin
        keys_d       = keys_q;
        last_key_d   = last_key_q;
        last_valid_d = last_valid_q;
        found        = 1'b0;
        for (int i = 0; i < N_KEYS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == keys_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] == CNT_LAST) begin
                    keys_d[i] = sync2_q[i];
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        press_d   = keys_d & ~keys_q;
        release_d = keys_q & ~keys_d;
        any_key_d = |keys_d;
        // Lowest-numbered key wins when several are pressed together.
        for (int i = 0; i < N_KEYS; i++) begin
            if (press_d[i] && !found) begin
                last_key_d   = 4'(i);
                last_valid_d = 1'b1;
                found        = 1'b1;
            end
        end
    end

    // State registers; reset clears every flop immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            pre_q        <= '0;
            keys_q       <= '0;
            press_q      <= '0;
            release_q    <= '0;
            any_key_q    <= 1'b0;
            last_key_q   <= '0;
            last_valid_q <= 1'b0;
            for (int i = 0; i < N_KEYS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= raw_pol;
            sync2_q      <= sync1_q;
            pre_q        <= pre_d;
            keys_q       <= keys_d;
            press_q      <= press_d;
            release_q    <= release_d;
            any_key_q    <= any_key_d;
            last_key_q   <= last_key_d;
            last_valid_q <= last_valid_d;
            for (int i = 0; i < N_KEYS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign keys_o       = keys_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign any_key_o    = any_key_q;
    assign last_key_o   = last_key_q;
    assign last_valid_o = last_valid_q;

endmodule

// File: doc/key_debouncer.md
Name: key_debouncer

Overview:
Front end for the 12-key piano. Synchronizes raw push-button/switch inputs, debounces each key independently against a shared millisecond-scale time base, and drives the clean `keys[11:0]` level vector consumed by the note-gating stage. Also produces per-key press/release strobes and a last-pressed-key index for display and sequencing logic.

Parameters:
N_KEYS, 12, number of keys (fixed at 12 for the piano; last_key width assumes N_KEYS<=16)
TICK_DIV, 50000, clk cycles per debounce tick (1 ms at 50 MHz)
DEB_TICKS, 8, consecutive ticks of stable differing input required to change a debounced key
ACTIVE_LOW, 0, 1 = raw inputs pressed-low; inversion is applied before synchronization

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
keys_raw  in  N_KEYS  raw asynchronous key inputs
keys  out  N_KEYS  debounced key levels, 1 = pressed
press  out  N_KEYS  one-cycle strobe on debounced rising edge, per key
release  out  N_KEYS  one-cycle strobe on debounced falling edge, per key
any_key  out  1  OR of keys
last_key  out  4  index of most recently pressed key
last_valid  out  1  set on first press after reset

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. All outputs, synchronizer flops, the prescaler and all per-key counters clear to 0 immediately on rst; no outputs change while rst is high.
- Reset values: keys=0, press=0, release=0, any_key=0, last_key=0, last_valid=0.
- Input path: optionally invert keys_raw (ACTIVE_LOW), then pass each bit through a 2-flop synchronizer. Call the output sync[i].
- Prescaler: counter runs 0..TICK_DIV-1 and wraps to 0. `tick` is high for exactly one cycle when counter==TICK_DIV-1. Counter width is clog2(TICK_DIV).
- Per-key counter cnt[i], width clog2(DEB_TICKS+1), updated every clk:
  - sync[i]==keys[i]: cnt[i] <= 0. Any bounce therefore discards accumulated progress.
  - Else if tick: if cnt[i]==DEB_TICKS-1, then keys[i] <= sync[i] and cnt[i] <= 0; otherwise cnt[i] <= cnt[i]+1.
  - Else: hold.
- Latency: for a clean raw edge, keys[i] changes between 2+(DEB_TICKS-1)*TICK_DIV and 3+DEB_TICKS*TICK_DIV clk edges after the raw change. The exact value depends on tick phase.
- Pulses longer than the synchronizer window but shorter than (DEB_TICKS-1)*TICK_DIV cycles never change keys.
- Strobes:
  - press[i] is registered and high for exactly the one cycle in which keys[i] first reads 1.
  - release[i] behaves the same way for the falling edge.
  - Per key, press and release are never high together.
- any_key: combinational OR of the keys register.
- last_key/last_valid:
  - Updated in the same cycle press is high.
  - If several press bits are high together, the lowest index wins.
  - Release does not affect last_key.
  - last_valid stays 1 until reset.
- Keys are independent; any number may be pressed or released simultaneously.
- Reset mid-debounce: progress is discarded. After rst falls, an input still held requires a full debounce from zero. The prescaler restarts at 0, so the first tick comes TICK_DIV cycles after rst falls.

Test Plan:
All scenarios use TICK_DIV=4, DEB_TICKS=3, ACTIVE_LOW=0 unless noted.
1. Reset with keys_raw=0, then hold keys_raw[0]=1 -> keys[0] rises 10..15 cycles later; press=12'h001 for exactly 1 cycle; last_key=0; last_valid=1; any_key=1.
2. Toggle keys_raw[5] every 3 cycles for 40 cycles, then hold 0 -> keys[5], press[5] and release[5] stay 0 throughout.
3. keys_raw=12'h0A0 in a single cycle -> keys[5] and keys[7] rise in the same cycle; press=12'h0A0 for 1 cycle; last_key=5.
4. Key 9 debounced high, then keys_raw[9]=0 -> release=12'h200 for 1 cycle 10..15 cycles later; keys=0; any_key=0; last_key stays 9.
5. keys_raw[3]=1, assert rst at cycle 7 for 2 cycles, raw still held -> all outputs 0 during rst; keys[3] rises no earlier than 2+2*4 cycles and no later than 3+3*4+4 cycles after rst deasserts.
6. ACTIVE_LOW=1, keys_raw=12'hFFE held -> keys=12'h001 after debounce; press[0] pulses once; no other bits set.
